// File: rtl/key_pulse_gen.sv
// Push-button conditioner: synchronizes and debounces a raw key, then emits one
// single-cycle enable pulse per accepted press plus the debounced key level.
module key_pulse_gen #(
  parameter int DEBOUNCE_CNT   = 20,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_en,
  output logic o_key_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic REL_LVL = KEY_ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             pressed;
  logic             en_d, level_d;

  // Sync flops rest at the released level so a key held through reset is
  // seen as a fresh press, never as an instantaneous pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= i_key;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = sync2_q ^ REL_LVL;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      o_en        <= 1'b0;
      o_key_level <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      o_en        <= en_d;
      o_key_level <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    en_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed) state_d = DEB_PRESS;
      end
      DEB_PRESS: begin
        if (!pressed) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!pressed) state_d = DEB_RELEASE;
      end
      DEB_RELEASE: begin
        // A press seen here is release bounce: back to HELD without a pulse.
        if (pressed) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    level_d = (state_d == HELD) || (state_d == DEB_RELEASE);
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen (DEBOUNCE_CNT=4, active-low key) with a
// small 3-state cycling FSM model fed by o_en.
module tb_key_pulse_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key;
  logic       o_en;
  logic       o_lvl;
  logic [1:0] ds_state;
  int         errors = 0;
  int         checks = 0;

  key_pulse_gen #(
    .DEBOUNCE_CNT  (4),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_key      (key),
    .o_en       (o_en),
    .o_key_level(o_lvl)
  );

  always #5 clk = ~clk;

  // Downstream 0 -> 1 -> 2 -> 0 FSM advanced by each enable pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ds_state <= 2'd0;
    else if (o_en) ds_state <= (ds_state == 2'd2) ? 2'd0 : ds_state + 2'd1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_release();
    key = 1'b0;
    tick(12);
    key = 1'b1;
    tick(12);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key   = 1'b1;
    tick(3);
    checks++;
    if ({o_en, o_lvl} !== 2'b00) begin
      errors++;
      $display("FAIL reset_hold: en,lvl=%b expected 00", {o_en, o_lvl});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      checks++;
      if ({o_en, o_lvl} !== 2'b00) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: en,lvl=%b expected 00", i, {o_en, o_lvl});
      end
    end
  endtask

  task automatic test_clean_press();
    key = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      checks++;
      if ({o_en, o_lvl} !== 2'b00) begin
        errors++;
        $display("FAIL clean_qual edge%0d: en,lvl=%b expected 00", i, {o_en, o_lvl});
      end
    end
    tick(1);
    checks++;
    if ({o_en, o_lvl} !== 2'b11) begin
      errors++;
      $display("FAIL clean_pulse: en,lvl=%b expected 11", {o_en, o_lvl});
    end
    for (int i = 8; i <= 40; i++) begin
      tick(1);
      checks++;
      if ({o_en, o_lvl} !== 2'b01) begin
        errors++;
        $display("FAIL clean_hold cyc%0d: en,lvl=%b expected 01", i, {o_en, o_lvl});
      end
    end
    key = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      checks++;
      if ({o_en, o_lvl} !== 2'b01) begin
        errors++;
        $display("FAIL clean_release_qual edge%0d: en,lvl=%b expected 01", i, {o_en, o_lvl});
      end
    end
    tick(1);
    checks++;
    if ({o_en, o_lvl} !== 2'b00) begin
      errors++;
      $display("FAIL clean_released: en,lvl=%b expected 00", {o_en, o_lvl});
    end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (o_en !== 1'b0) begin
        errors++;
        $display("FAIL clean_release_pulse: en=%b expected 0", o_en);
      end
    end
  endtask

  task automatic test_bouncy_press();
    for (int i = 0; i < 12; i++) begin
      key = ((i / 2) % 2 == 1);
      tick(1);
      checks++;
      if ({o_en, o_lvl} !== 2'b00) begin
        errors++;
        $display("FAIL bounce cyc%0d: en,lvl=%b expected 00", i, {o_en, o_lvl});
      end
    end
    key = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      checks++;
      if ({o_en, o_lvl} !== 2'b00) begin
        errors++;
        $display("FAIL bounce_qual edge%0d: en,lvl=%b expected 00", i, {o_en, o_lvl});
      end
    end
    tick(1);
    checks++;
    if ({o_en, o_lvl} !== 2'b11) begin
      errors++;
      $display("FAIL bounce_pulse: en,lvl=%b expected 11", {o_en, o_lvl});
    end
    tick(1);
    checks++;
    if ({o_en, o_lvl} !== 2'b01) begin
      errors++;
      $display("FAIL bounce_after: en,lvl=%b expected 01", {o_en, o_lvl});
    end
    key = 1'b1;
    tick(12);
  endtask

  task automatic test_short_glitch();
    key = 1'b0;
    tick(3);
    key = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      checks++;
      if ({o_en, o_lvl} !== 2'b00) begin
        errors++;
        $display("FAIL glitch cyc%0d: en,lvl=%b expected 00", i, {o_en, o_lvl});
      end
    end
  endtask

  task automatic test_release_bounce();
    key = 1'b0;
    tick(7);
    checks++;
    if ({o_en, o_lvl} !== 2'b11) begin
      errors++;
      $display("FAIL relb_pulse: en,lvl=%b expected 11", {o_en, o_lvl});
    end
    tick(1);
    key = 1'b1;
    tick(2);
    key = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      checks++;
      if ({o_en, o_lvl} !== 2'b01) begin
        errors++;
        $display("FAIL relb_hold cyc%0d: en,lvl=%b expected 01", i, {o_en, o_lvl});
      end
    end
    key = 1'b1;
    tick(12);
    checks++;
    if ({o_en, o_lvl} !== 2'b00) begin
      errors++;
      $display("FAIL relb_released: en,lvl=%b expected 00", {o_en, o_lvl});
    end
  endtask

  task automatic test_chain();
    logic [1:0] exp_seq [4];
    exp_seq = '{2'd1, 2'd2, 2'd0, 2'd1};
    key   = 1'b1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    checks++;
    if (ds_state !== 2'd0) begin
      errors++;
      $display("FAIL chain_init: state=%0d expected 0", ds_state);
    end
    for (int i = 0; i < 4; i++) begin
      press_release();
      checks++;
      if (ds_state !== exp_seq[i]) begin
        errors++;
        $display("FAIL chain_press%0d: state=%0d expected %0d", i, ds_state, exp_seq[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    key = 1'b0;
    tick(5);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_en, o_lvl} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_async: en,lvl=%b expected 00", {o_en, o_lvl});
    end
    tick(2);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      checks++;
      if ({o_en, o_lvl} !== 2'b00) begin
        errors++;
        $display("FAIL rstmid_qual edge%0d: en,lvl=%b expected 00", i, {o_en, o_lvl});
      end
    end
    tick(1);
    checks++;
    if ({o_en, o_lvl} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_pulse: en,lvl=%b expected 11", {o_en, o_lvl});
    end
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if ({o_en, o_lvl} !== 2'b01) begin
        errors++;
        $display("FAIL rstmid_hold cyc%0d: en,lvl=%b expected 01", i, {o_en, o_lvl});
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_en, o_lvl} !== 2'b00) begin
      errors++;
      $display("FAIL rst_held_async: en,lvl=%b expected 00", {o_en, o_lvl});
    end
    key = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    checks++;
    if ({o_en, o_lvl} !== 2'b00) begin
      errors++;
      $display("FAIL rst_after_idle: en,lvl=%b expected 00", {o_en, o_lvl});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 1'b1;
    test_reset();
    test_clean_press();
    test_bouncy_press();
    test_short_glitch();
    test_release_bounce();
    test_chain();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
